// File: rtl/shift_right_seq.sv
// Iterative right shifter (logical/arithmetic) applying one power-of-two stage
// per clock, with valid/ready handshakes on input and output.
module shift_right_seq #(
  parameter int N    = 32,
  parameter int LOGN = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  input  logic         arith,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Z
);

  localparam int KW = (LOGN > 1) ? $clog2(LOGN) : 1;
  localparam logic [KW-1:0] K_TOP  = KW'(LOGN - 1);
  localparam logic [KW-1:0] K_ZERO = KW'(0);
  localparam logic [KW-1:0] K_ONE  = KW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [N-1:0]    data;
  logic [LOGN-1:0] amt;
  logic [KW-1:0]   k;
  logic            fill;

  logic [LOGN-1:0] step;
  logic [N-1:0]    stage_shift;
  logic [N-1:0]    stage_next;
  logic            overflow;
  logic            in_fill;

  assign in_ready = (state == IDLE);
  assign Z        = data;
  assign overflow = |Y[N-1:LOGN];
  assign in_fill  = arith & X[N-1];

  // Single shared stage: shift by 2^k, filling vacated bits with the captured fill bit.
  always_comb begin
    step        = {{(LOGN-1){1'b0}}, 1'b1} << k;
    stage_shift = N'($signed({fill, data}) >>> step);
    if (amt[k]) begin
      stage_next = stage_shift;
    end else begin
      stage_next = data;
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      data      <= {N{1'b0}};
      amt       <= {LOGN{1'b0}};
      k         <= K_TOP;
      fill      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            amt   <= Y[LOGN-1:0];
            fill  <= in_fill;
            k     <= K_TOP;
            data  <= overflow ? {N{in_fill}} : X;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          data <= stage_next;
          if (k == K_ZERO) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            k <= k - K_ONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed and random self-checking bench for shift_right_seq.
module tb_shift_right_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] X;
  logic [31:0] Y;
  logic        arith;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Z;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int accepts  = 0;
  int hshakes  = 0;
  int last_acc = 0;
  int prev_acc = 0;

  shift_right_seq #(.N(32), .LOGN(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .X(X), .Y(Y), .arith(arith), .out_valid(out_valid),
    .out_ready(out_ready), .Z(Z)
  );

  always #5 clk = ~clk;

  // Handshake monitor.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n && in_valid && in_ready) begin
      accepts  = accepts + 1;
      prev_acc = last_acc;
      last_acc = cyc;
    end
    if (rst_n && out_valid && out_ready) hshakes = hshakes + 1;
  end

  function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [31:0] y,
                                            input logic a);
    logic signed [31:0] sx;
    sx = x;
    if (y >= 32'd32) return (a && x[31]) ? 32'hFFFF_FFFF : 32'h0000_0000;
    else if (a) return sx >>> y;
    else return x >> y;
  endfunction

  // Accept one operand, scramble inputs afterwards, wait for the result, then release it.
  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic a,
                       output logic [31:0] z, output int lat, output logic ready_low,
                       output logic ready_after);
    out_ready = 1'b1;
    X = x; Y = y; arith = a; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; X = ~x; Y = 32'hFFFF_FFFF; arith = ~a;
    lat = 0;
    ready_low = 1'b1;
    do begin
      if (in_ready !== 1'b0) ready_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end while (out_valid !== 1'b1 && lat < 20);
    if (in_ready !== 1'b0) ready_low = 1'b0;
    z = Z;
    @(posedge clk); #1;
    ready_after = (in_ready === 1'b1) && (out_valid === 1'b0);
  endtask

  task automatic test_reset;
    #3;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (Z !== 32'h0) begin n_fail++; $display("FAIL reset_z got %h want 00000000", Z); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_logical;
    logic [31:0] z; int lat; logic rl, ra;
    do_op(32'h8000_0000, 32'd4, 1'b0, z, lat, rl, ra);
    n_checks++; if (z !== 32'h0800_0000) begin n_fail++; $display("FAIL logical_z got %h want 08000000", z); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL logical_latency got %0d want 5", lat); end
    n_checks++; if (rl !== 1'b1) begin n_fail++; $display("FAIL logical_in_ready_low got %b want 1", rl); end
    n_checks++; if (ra !== 1'b1) begin n_fail++; $display("FAIL logical_idle_after got %b want 1", ra); end
  endtask

  task automatic test_arith;
    logic [31:0] z; int lat; logic rl, ra;
    do_op(32'h8000_0000, 32'd4, 1'b1, z, lat, rl, ra);
    n_checks++; if (z !== 32'hF800_0000) begin n_fail++; $display("FAIL arith_neg_z got %h want f8000000", z); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL arith_latency got %0d want 5", lat); end
    do_op(32'h7FFF_FFFF, 32'd31, 1'b1, z, lat, rl, ra);
    n_checks++; if (z !== 32'h0000_0000) begin n_fail++; $display("FAIL arith_pos31_z got %h want 00000000", z); end
  endtask

  task automatic test_overflow;
    logic [31:0] vx [7] = '{32'h8000_0001, 32'h8000_0001, 32'h8000_0001, 32'h1234_5678,
                            32'hDEAD_BEEF, 32'h8000_0000, 32'hC000_0000};
    logic [31:0] vy [7] = '{32'd32, 32'd32, 32'h0001_0003, 32'h0001_0003,
                            32'd0, 32'd31, 32'd1};
    logic        va [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ve [7] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000,
                            32'hDEAD_BEEF, 32'h0000_0001, 32'hE000_0000};
    logic [31:0] z; int lat; logic rl, ra;
    for (int i = 0; i < 7; i++) begin
      do_op(vx[i], vy[i], va[i], z, lat, rl, ra);
      n_checks++; if (z !== ve[i]) begin n_fail++; $display("FAIL overflow_z[%0d] got %h want %h", i, z, ve[i]); end
      n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL overflow_latency[%0d] got %0d want 5", i, lat); end
    end
  endtask

  task automatic test_back_pressure;
    int n; logic [31:0] z0; logic stable;
    int hs0;
    out_ready = 1'b0;
    X = 32'h0000_00F0; Y = 32'd4; arith = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    z0 = Z;
    hs0 = hshakes;
    n_checks++; if (z0 !== 32'h0000_000F) begin n_fail++; $display("FAIL bp_first_z got %h want 0000000f", z0); end
    X = 32'hF000_0000; Y = 32'd8; arith = 1'b1; in_valid = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (Z !== z0 || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    n_checks++; if (stable !== 1'b1) begin n_fail++; $display("FAIL bp_frozen got %b want 1 (z=%h ov=%b ir=%b)", stable, Z, out_valid, in_ready); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_next_accept got in_ready=%b want 0", in_ready); end
    n_checks++; if (hshakes - hs0 !== 1) begin n_fail++; $display("FAIL bp_handshakes got %0d want 1", hshakes - hs0); end
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    n_checks++; if (Z !== 32'hFFF0_0000) begin n_fail++; $display("FAIL bp_second_z got %h want fff00000", Z); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int start; int n;
    out_ready = 1'b1;
    X = 32'h0000_0100; Y = 32'd8; arith = 1'b0; in_valid = 1'b1;
    start = accepts;
    n = 0;
    while (accepts < start + 2 && n < 40) begin @(posedge clk); #1; n++; end
    in_valid = 1'b0;
    n_checks++; if (last_acc - prev_acc !== 7) begin n_fail++; $display("FAIL b2b_interval got %0d want 7", last_acc - prev_acc); end
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
  endtask

  task automatic test_reset_mid_op;
    logic [31:0] z; int lat; logic rl, ra; logic saw_valid;
    out_ready = 1'b1;
    X = 32'hFFFF_0000; Y = 32'd1; arith = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    n_checks++; if (Z !== 32'h0) begin n_fail++; $display("FAIL midrst_z got %h want 00000000", Z); end
    @(negedge clk); rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) saw_valid = 1'b1;
    end
    n_checks++; if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_aborted got out_valid seen=%b want 0", saw_valid); end
    do_op(32'h0000_F000, 32'd12, 1'b0, z, lat, rl, ra);
    n_checks++; if (z !== 32'h0000_000F) begin n_fail++; $display("FAIL midrst_after_z got %h want 0000000f", z); end
  endtask

  task automatic test_random;
    logic [31:0] x, y, exp; logic a; int n; int acc0, hs0; int stall;
    acc0 = accepts; hs0 = hshakes;
    for (int t = 0; t < 1000; t++) begin
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
      a = 1'($urandom_range(0, 1));
      exp = ref_shift(x, y, a);
      out_ready = 1'b0;
      X = x; Y = y; arith = a; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; X = $urandom; Y = $urandom;
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      stall = $urandom_range(0, 2);
      for (int s = 0; s < stall; s++) begin @(posedge clk); #1; end
      n_checks++; if (Z !== exp) begin n_fail++; $display("FAIL random_z[%0d] x=%h y=%h a=%b got %h want %h", t, x, y, a, Z, exp); end
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    n_checks++; if (accepts - acc0 !== 1000) begin n_fail++; $display("FAIL random_accepts got %0d want 1000", accepts - acc0); end
    n_checks++; if (hshakes - hs0 !== 1000) begin n_fail++; $display("FAIL random_handshakes got %0d want 1000", hshakes - hs0); end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    X = 32'h0; Y = 32'h0; arith = 1'b0;
    test_reset;
    test_logical;
    test_arith;
    test_overflow;
    test_back_pressure;
    test_back_to_back;
    test_reset_mid_op;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
